// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/lap/clear stopwatch driving four BCD seven-segment digits (SS.hh).
// Define STOPWATCH_LAP_EN to enable the LAP state, display latch and LAP_LED.
module stopwatch_ctrl #(
   parameter int CLK_HZ  = 25175000,
   parameter int TICK_HZ = 100
) (
   input  logic       MCLK,
   input  logic       RESET_N,
   input  logic       BTN_SS_N,
   input  logic       BTN_LC_N,
   output logic [6:0] DISP1,
   output logic [6:0] DISP2,
   output logic [6:0] DISP3,
   output logic [6:0] DISP4,
   output logic       DISP1_DP,
   output logic       DISP2_DP,
   output logic       DISP3_DP,
   output logic       DISP4_DP,
   output logic       RUN_LED,
   output logic       LAP_LED,
   output logic       WRAP
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW = $clog2(DIV);
   localparam logic [15:0] MAX = 16'h5999;
   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;
   state_t state, nxt;
   logic ss_q, lc_q, ss_ev, lc_ev, counting, tick;
   logic [PW-1:0] pre;
   logic [3:0][3:0] cnt, cnt_nxt, src;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   // SS beats LC when both fall in the same cycle
   always_comb begin
      ss_ev = ss_q & ~BTN_SS_N;
      lc_ev = lc_q & ~BTN_LC_N & ~ss_ev;
      nxt = state;
      case (state)
         IDLE: nxt = ss_ev ? RUN : IDLE;
`ifdef STOPWATCH_LAP_EN
         RUN:  nxt = ss_ev ? STOP : lc_ev ? LAP : RUN;
`else
         RUN:  nxt = ss_ev ? STOP : RUN;
`endif
         LAP:  nxt = ss_ev ? STOP : lc_ev ? RUN : LAP;
         STOP: nxt = ss_ev ? RUN : lc_ev ? IDLE : STOP;
         default: nxt = IDLE;
      endcase
   end

   assign counting = (state == RUN) || (state == LAP);
   assign tick = counting && (pre == PW'(DIV - 1));

   always_comb begin
      cnt_nxt = cnt;
      if (tick) begin
         cnt_nxt[0] = (cnt[0] == 4'd9) ? 4'd0 : cnt[0] + 4'd1;
         if (cnt[0] == 4'd9) begin
            cnt_nxt[1] = (cnt[1] == 4'd9) ? 4'd0 : cnt[1] + 4'd1;
            if (cnt[1] == 4'd9) begin
               cnt_nxt[2] = (cnt[2] == 4'd9) ? 4'd0 : cnt[2] + 4'd1;
               if (cnt[2] == 4'd9)
                  cnt_nxt[3] = (cnt[3] == 4'd5) ? 4'd0 : cnt[3] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         ss_q <= 1'b1;
         lc_q <= 1'b1;
         pre <= '0;
         cnt <= '0;
         WRAP <= 1'b0;
         DISP1 <= 7'b1000000;
         DISP2 <= 7'b1000000;
         DISP3 <= 7'b1000000;
         DISP4 <= 7'b1000000;
      end else begin
         state <= nxt;
         ss_q <= BTN_SS_N;
         lc_q <= BTN_LC_N;
         WRAP <= tick && (cnt == MAX);
         if (nxt == IDLE) begin
            pre <= '0;
            cnt <= '0;
         end else begin
            if (counting)
               pre <= tick ? '0 : pre + PW'(1);
            cnt <= cnt_nxt;
         end
         DISP1 <= seg(src[3]);
         DISP2 <= seg(src[2]);
         DISP3 <= seg(src[1]);
         DISP4 <= seg(src[0]);
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [3:0][3:0] lat;
   // snapshot includes a tick landing on the same edge
   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N)
         lat <= '0;
      else if (state == RUN && nxt == LAP)
         lat <= cnt_nxt;
   end
   assign src = (state == LAP) ? lat : cnt;
   assign LAP_LED = (state == LAP);
`else
   assign src = cnt;
   assign LAP_LED = 1'b0;
`endif

   assign RUN_LED = counting;
   assign DISP1_DP = 1'b1;
   assign DISP2_DP = 1'b0;
   assign DISP3_DP = 1'b1;
   assign DISP4_DP = 1'b1;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: random and directed button stimulus against a hundredths-count reference model.
// Honours STOPWATCH_LAP_EN the same way as the design.
module tb_stopwatch_ctrl;
   localparam int DIV = 10;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;
   localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct packed {
      logic [27:0] disp;
      logic [3:0]  dp;
      logic        run;
      logic        lap;
      logic        wrap;
   } exp_t;

   logic MCLK = 1'b0, RESET_N = 1'b0, BTN_SS_N = 1'b1, BTN_LC_N = 1'b1;
   logic [6:0] DISP1, DISP2, DISP3, DISP4;
   logic DISP1_DP, DISP2_DP, DISP3_DP, DISP4_DP, RUN_LED, LAP_LED, WRAP;

   exp_t q[$];
   int vectors = 0, miscompares = 0;
   int m_mode = M_IDLE, m_cnt = 0, m_pre = 0, m_lat = 0;
   bit m_pss = 1'b1, m_plc = 1'b1;

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .BTN_SS_N(BTN_SS_N), .BTN_LC_N(BTN_LC_N),
      .DISP1(DISP1), .DISP2(DISP2), .DISP3(DISP3), .DISP4(DISP4),
      .DISP1_DP(DISP1_DP), .DISP2_DP(DISP2_DP), .DISP3_DP(DISP3_DP), .DISP4_DP(DISP4_DP),
      .RUN_LED(RUN_LED), .LAP_LED(LAP_LED), .WRAP(WRAP)
   );

   always #5 MCLK = ~MCLK;

   function automatic exp_t outs(input int shown, input bit wr);
      exp_t e;
      e.disp = {SEG[shown / 1000], SEG[(shown / 100) % 10], SEG[(shown / 10) % 10], SEG[shown % 10]};
      e.dp = 4'b1011;
      e.run = (m_mode == M_RUN) || (m_mode == M_LAP);
      e.lap = (m_mode == M_LAP);
      e.wrap = wr;
      return e;
   endfunction

   task automatic cmp(input string name, input exp_t e);
      exp_t got;
      got = {DISP1, DISP2, DISP3, DISP4, DISP1_DP, DISP2_DP, DISP3_DP, DISP4_DP, RUN_LED, LAP_LED, WRAP};
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got disp=%h dp=%b run=%b lap=%b wrap=%b, expected disp=%h dp=%b run=%b lap=%b wrap=%b",
                  name, $time, got.disp, got.dp, got.run, got.lap, got.wrap, e.disp, e.dp, e.run, e.lap, e.wrap);
      end
   endtask

   // Drive one cycle's inputs and queue what the outputs must be after the next edge.
   task automatic step(input bit rst, input bit ss, input bit lc);
      int shown;
      bit ss_ev, lc_ev, tick, wr;
      @(negedge MCLK);
      RESET_N = rst;
      BTN_SS_N = ss;
      BTN_LC_N = lc;
      if (!rst) begin
         m_mode = M_IDLE;
         m_cnt = 0;
         m_pre = 0;
         m_lat = 0;
         m_pss = 1'b1;
         m_plc = 1'b1;
         q.push_back(outs(0, 1'b0));
      end else begin
         shown = (m_mode == M_LAP) ? m_lat : m_cnt;
         ss_ev = m_pss && !ss;
         lc_ev = m_plc && !lc && !ss_ev;
         m_pss = ss;
         m_plc = lc;
         tick = (m_mode == M_RUN || m_mode == M_LAP) && m_pre == DIV - 1;
         if (m_mode == M_RUN || m_mode == M_LAP) m_pre = (m_pre + 1) % DIV;
         if (tick) m_cnt = (m_cnt + 1) % 6000;
         wr = tick && m_cnt == 0;
         case (m_mode)
            M_IDLE: if (ss_ev) m_mode = M_RUN;
            M_RUN: begin
               if (ss_ev) m_mode = M_STOP;
               else if (lc_ev && LAP_EN) begin
                  m_mode = M_LAP;
                  m_lat = m_cnt;
               end
            end
            M_LAP: begin
               if (ss_ev) m_mode = M_STOP;
               else if (lc_ev) m_mode = M_RUN;
            end
            default: begin
               if (ss_ev) m_mode = M_RUN;
               else if (lc_ev) begin
                  m_mode = M_IDLE;
                  m_cnt = 0;
                  m_pre = 0;
               end
            end
         endcase
         q.push_back(outs(shown, wr));
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) step(1'b1, 1'b1, 1'b1);
   endtask

   task automatic get_running();
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4 && m_mode != M_RUN; i++) begin
         step(1'b1, 1'b0, 1'b1);
         step(1'b1, 1'b1, 1'b1);
      end
   endtask

   always @(posedge MCLK) begin
      #1;
      if (q.size() > 0) cmp("cycle", q.pop_front());
   end

   initial begin
      bit ss, lc;
      repeat (3) step(1'b0, 1'b1, 1'b1);
      idle_cycles(3);
      step(1'b1, 1'b1, 1'b0);
      idle_cycles(5);
      step(1'b1, 1'b0, 1'b1);
      idle_cycles(1005);
      ss = 1'b1;
      lc = 1'b1;
      repeat (6000) begin
         if ($urandom_range(0, 24) == 0) ss = !ss;
         if ($urandom_range(0, 24) == 0) lc = !lc;
         step(1'b1, ss, lc);
      end
      get_running();
      idle_cycles(7);
      step(1'b1, 1'b0, 1'b0);
      idle_cycles(20);
      repeat (100) step(1'b1, 1'b0, 1'b1);
      idle_cycles(30);
      get_running();
      idle_cycles(300);
      step(1'b0, 1'b1, 1'b1);
      #1 cmp("async_reset", outs(0, 1'b0));
      repeat (2) step(1'b0, 1'b1, 1'b1);
      idle_cycles(20);
      step(1'b1, 1'b0, 1'b1);
      idle_cycles(60050);
      step(1'b1, 1'b1, 1'b0);
      idle_cycles(200);
      step(1'b1, 1'b1, 1'b0);
      idle_cycles(50);
      step(1'b1, 1'b0, 1'b1);
      idle_cycles(5);
      step(1'b1, 1'b1, 1'b0);
      idle_cycles(10);
      @(posedge MCLK);
      #2;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences the board's timer datapath: a tick prescaler, a 4-digit BCD counter (SS.hh, 00.00–59.99) and the four on-board seven-segment displays. It consumes two debounced, active-low push-button levels from the existing debouncer instances and runs a run/stop/lap/clear state machine. The block drives DISP1..DISP4 and a run indicator LED directly from the top level.

## Interface
- CLK_HZ, 25175000, MCLK frequency in Hz
- TICK_HZ, 100, counter increment rate in Hz; DIV = CLK_HZ/TICK_HZ (integer, ≥2)
- MCLK  input  1  main clock; all logic on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- BTN_SS_N  input  1  start/stop button, debounced level, 0 = pressed
- BTN_LC_N  input  1  lap/clear button, debounced level, 0 = pressed
- DISP1..DISP4  output  7 each  segments {g,f,e,d,c,b,a}, active-low; DISP1 = seconds tens … DISP4 = hundredths units
- DISP1_DP..DISP4_DP  output  1 each  decimal points, active-low
- RUN_LED  output  1  1 while counting (RUN or LAP)
- LAP_LED  output  1  1 while display frozen (LAP)
- WRAP  output  1  one-cycle pulse on 59.99 → 00.00

## Operation
- Press event: registered copy of each button (reset value 1); event = prev==1 && current==0. Only falling edges act; held buttons produce one event.
- States: IDLE, RUN, STOP, LAP. Reset → IDLE.
- IDLE: SS → RUN. LC ignored.
- RUN: SS → STOP; LC → LAP (snapshot the live count into the display latch).
- LAP: SS → STOP (display returns to live count); LC → RUN (display follows live count again).
- STOP: SS → RUN (resume); LC → IDLE (count and prescaler cleared to 0).
- Same-cycle events on both buttons: SS wins, LC discarded.
- Prescaler: 0..DIV-1, advances only in RUN/LAP; holds its value in STOP (partial tick kept); cleared in IDLE. Tick = prescaler == DIV-1 while counting; prescaler then wraps to 0.
- Counter: four BCD digits, each 0–9, seconds tens 0–5. Tick increments the hundredths units digit with ripple carry. 59.99 + tick → 00.00, WRAP = 1 for that cycle; counting continues.
- Display source: latch in LAP, live count otherwise. Digits decoded to active-low segments (0 = 7'b1000000, 8 = 7'b0000000). DISP2_DP = 0 (lit); other DPs = 1.

## Timing
- Reset values: state IDLE, count 00.00, prescaler 0, DISP1..4 = 7'b1000000, DISP2_DP = 0, other DPs = 1, RUN_LED = 0, LAP_LED = 0, WRAP = 0.
- Button falls before edge k → state updated at edge k; RUN_LED/LAP_LED are state decodes, valid after edge k.
- In RUN, first tick occurs DIV cycles after entering from IDLE.
- Count updated at the tick edge; DISP outputs registered, change one edge after the count changes.
- WRAP asserted on the edge at which the count becomes 00.00.
- Entering LAP: latch captures the count present at the same edge (any tick at that edge is included).
- RESET_N low at any time forces reset values immediately, independent of MCLK; first event is accepted on the first edge after release.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state, display latch and LAP_LED as described.
- Not defined: no LAP state or latch; LC in RUN ignored; LAP_LED tied 0; all other behaviour identical.

## Test plan
- Reset: RESET_N=0 mid-count at 12.34 → all DISP = 7'b1000000 immediately, DISP2_DP=0, RUN_LED=0; released → IDLE, remains 00.00 with no button.
- Count (CLK_HZ=1000, TICK_HZ=100, DIV=10): SS press → RUN_LED=1, 10 cycles later display 00.01; 1000 cycles → 01.00.
- Wrap: preload/run to 59.99, next tick → 00.00, WRAP high exactly one cycle, RUN_LED stays 1.
- Stop/resume/clear: stop at prescaler 6, wait 50 cycles, SS → next tick after 4 cycles; then SS, LC → 00.00, IDLE; LC in IDLE → no change.
- Lap (STOPWATCH_LAP_EN): LC at 00.05 → display holds 00.05, LAP_LED=1 while count advances; LC → display shows live count one edge later.
- Priority/hold: SS and LC fall same cycle in RUN → STOP, no LAP; SS held low 100 cycles → exactly one transition.
